// File: rtl/writeback_unit.sv
// writeback_unit: sole driver of the register file write port; merges ALU results with in-order load responses.
// Latency: 1 cycle from selection to RegWrite; each competing load response delays an ALU/skid write by 1 cycle.
// Backpressure: alu_ready low while the 1-entry skid is full; ld_req_ready low when the tag FIFO is full or rd is already pending; load responses are never stalled.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   alu_valid/alu_ready         ALU result handshake (alu_rd, alu_data)
//   ld_req_valid/ld_req_ready   load issue handshake, reserves ld_rd
//   ld_resp_valid/ld_resp_data  in-order load data, no backpressure
//   rs1, rs2, rd_chk -> stall   decode-stage hazard check
//   RegWrite/write_addr/write_data  registered register file write port
//   ld_count                    loads in flight
//   resp_err                    sticky: response arrived with no load in flight
module writeback_unit #(
  parameter int DEPTH = 4,
  parameter int DW    = 18,
  parameter int AW    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [AW-1:0]            alu_rd,
  input  logic [DW-1:0]            alu_data,
  input  logic                     ld_req_valid,
  output logic                     ld_req_ready,
  input  logic [AW-1:0]            ld_rd,
  input  logic                     ld_resp_valid,
  input  logic [DW-1:0]            ld_resp_data,
  input  logic [AW-1:0]            rs1,
  input  logic [AW-1:0]            rs2,
  input  logic [AW-1:0]            rd_chk,
  output logic                     stall,
  output logic                     RegWrite,
  output logic [AW-1:0]            write_addr,
  output logic [DW-1:0]            write_data,
  output logic [$clog2(DEPTH):0]   ld_count,
  output logic                     resp_err
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << AW;

  // Load tag FIFO: destination registers of loads in flight, issue order.
  logic [AW-1:0]   tag_mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  logic            skid_vld;
  logic [AW-1:0]   skid_rd;
  logic [DW-1:0]   skid_data;

  logic            wb_is_load;

  logic            push;
  logic            pop;
  logic            alu_acc;

  logic            sel_vld;
  logic            sel_load;
  logic [AW-1:0]   sel_rd;
  logic [DW-1:0]   sel_data;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign ld_req_ready = !full && !pending[ld_rd];
  assign alu_ready    = !skid_vld;
  assign push         = ld_req_valid && ld_req_ready;
  assign pop          = ld_resp_valid && !empty;
  assign alu_acc      = alu_valid && alu_ready;
  assign ld_count     = count;
  assign stall        = pending[rs1] | pending[rs2] | pending[rd_chk] | (skid_vld && alu_valid);

  // One write per cycle: load response, then skid, then a fresh ALU result.
  always_comb begin
    sel_vld  = 1'b0;
    sel_load = 1'b0;
    sel_rd   = alu_rd;
    sel_data = alu_data;
    if (pop) begin
      sel_vld  = 1'b1;
      sel_load = 1'b1;
      sel_rd   = tag_mem[rd_ptr];
      sel_data = ld_resp_data;
    end else if (skid_vld) begin
      sel_vld  = 1'b1;
      sel_rd   = skid_rd;
      sel_data = skid_data;
    end else if (alu_acc) begin
      sel_vld  = 1'b1;
    end
  end

  // A load's reservation is released on the edge where its data is written,
  // so a new load to the same register can only be accepted after that.
  always_comb begin
    pending_nxt = pending;
    if (RegWrite && wb_is_load) pending_nxt[write_addr] = 1'b0;
    if (push) pending_nxt[ld_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= ld_rd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pending    <= '0;
      skid_vld   <= 1'b0;
      skid_rd    <= '0;
      skid_data  <= '0;
      RegWrite   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      wb_is_load <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      pending <= pending_nxt;

      // Skid holds an accepted ALU result that lost to a load response;
      // it drains on the first cycle without a response.
      if (skid_vld) begin
        if (!pop) skid_vld <= 1'b0;
      end else if (alu_acc && pop) begin
        skid_vld  <= 1'b1;
        skid_rd   <= alu_rd;
        skid_data <= alu_data;
      end

      RegWrite   <= sel_vld;
      wb_is_load <= sel_load;
      if (sel_vld) begin
        write_addr <= sel_rd;
        write_data <= sel_data;
      end

      if (ld_resp_valid && empty) resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

  localparam int DEPTH = 4;
  localparam int DW    = 18;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          ld_req_valid;
  logic          ld_req_ready;
  logic [AW-1:0] ld_rd;
  logic          ld_resp_valid;
  logic [DW-1:0] ld_resp_data;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic [AW-1:0] rd_chk;
  logic          stall;
  logic          RegWrite;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic [2:0]    ld_count;
  logic          resp_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  writeback_unit #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .ld_req_valid (ld_req_valid),
    .ld_req_ready (ld_req_ready),
    .ld_rd        (ld_rd),
    .ld_resp_valid(ld_resp_valid),
    .ld_resp_data (ld_resp_data),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd_chk       (rd_chk),
    .stall        (stall),
    .RegWrite     (RegWrite),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .ld_count     (ld_count),
    .resp_err     (resp_err)
  );

  // One cycle of directed stimulus and the outputs expected while it is applied.
  typedef struct packed {
    logic          av;
    logic [AW-1:0] ard;
    logic [DW-1:0] adat;
    logic          lv;
    logic [AW-1:0] lrd;
    logic          rv;
    logic [DW-1:0] rdat;
    logic [AW-1:0] rs;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          stl;
    logic          ar;
    logic          lr;
    logic [2:0]    cnt;
  } vec_t;

  vec_t tbl [13];

  // Reference model: loads in flight as a queue of rd, ALU writes waiting for
  // a free port as a queue, and the write currently on the port.
  logic [AW-1:0]    m_tq [$];
  logic [AW+DW-1:0] m_aq [$];
  logic             m_we;
  logic [AW-1:0]    m_wa;
  logic [DW-1:0]    m_wd;
  logic             m_isload;
  logic             m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid     = 1'b0;
    alu_rd        = '0;
    alu_data      = '0;
    ld_req_valid  = 1'b0;
    ld_rd         = '0;
    ld_resp_valid = 1'b0;
    ld_resp_data  = '0;
    rs1           = '0;
    rs2           = '0;
    rd_chk        = '0;
  endtask

  function automatic logic m_pend(input logic [AW-1:0] r);
    foreach (m_tq[i]) if (m_tq[i] == r) return 1'b1;
    return m_we && m_isload && (m_wa == r);
  endfunction

  task automatic model_reset();
    m_tq.delete();
    m_aq.delete();
    m_we     = 1'b0;
    m_wa     = '0;
    m_wd     = '0;
    m_isload = 1'b0;
    m_err    = 1'b0;
  endtask

  // Compare DUT against the model for the current inputs, then advance the model.
  task automatic model_step(input int c);
    logic             e_lr;
    logic             e_ar;
    logic             e_stl;
    logic             n_we;
    logic             n_isload;
    logic [AW+DW-1:0] ent;
    e_lr  = (m_tq.size() < DEPTH) && !m_pend(ld_rd);
    e_ar  = (m_aq.size() == 0);
    e_stl = m_pend(rs1) | m_pend(rs2) | m_pend(rd_chk) | ((m_aq.size() != 0) && alu_valid);
    chk($sformatf("rnd%0d.ld_req_ready", c), 32'(ld_req_ready), 32'(e_lr));
    chk($sformatf("rnd%0d.alu_ready", c), 32'(alu_ready), 32'(e_ar));
    chk($sformatf("rnd%0d.stall", c), 32'(stall), 32'(e_stl));
    chk($sformatf("rnd%0d.RegWrite", c), 32'(RegWrite), 32'(m_we));
    chk($sformatf("rnd%0d.write_addr", c), 32'(write_addr), 32'(m_wa));
    chk($sformatf("rnd%0d.write_data", c), 32'(write_data), 32'(m_wd));
    chk($sformatf("rnd%0d.ld_count", c), 32'(ld_count), 32'(m_tq.size()));
    chk($sformatf("rnd%0d.resp_err", c), 32'(resp_err), 32'(m_err));

    n_we     = 1'b0;
    n_isload = 1'b0;
    if (alu_valid && e_ar) m_aq.push_back({alu_rd, alu_data});
    if (ld_resp_valid) begin
      if (m_tq.size() > 0) begin
        m_wa     = m_tq.pop_front();
        m_wd     = ld_resp_data;
        n_we     = 1'b1;
        n_isload = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    if (!n_we && m_aq.size() > 0) begin
      ent  = m_aq.pop_front();
      m_wa = ent[AW+DW-1:DW];
      m_wd = ent[DW-1:0];
      n_we = 1'b1;
    end
    if (ld_req_valid && e_lr) m_tq.push_back(ld_rd);
    m_we     = n_we;
    m_isload = n_isload;
  endtask

  logic [DW-1:0] rd_vals [4];

  initial begin
    //          av    ard    adat       lv    lrd    rv    rdat       rs   | we   wa     wd         stl   ar    lr    cnt
    tbl[0]  = '{1'b1, 4'd3, 18'h2ABCD, 1'b0, 4'd0, 1'b0, 18'h00000, 4'd0, 1'b0, 4'd0, 18'h00000, 1'b0, 1'b1, 1'b1, 3'd0};
    tbl[1]  = '{1'b0, 4'd0, 18'h00000, 1'b0, 4'd0, 1'b0, 18'h00000, 4'd0, 1'b1, 4'd3, 18'h2ABCD, 1'b0, 1'b1, 1'b1, 3'd0};
    tbl[2]  = '{1'b0, 4'd0, 18'h00000, 1'b1, 4'd5, 1'b0, 18'h00000, 4'd0, 1'b0, 4'd3, 18'h2ABCD, 1'b0, 1'b1, 1'b1, 3'd0};
    tbl[3]  = '{1'b0, 4'd0, 18'h00000, 1'b0, 4'd0, 1'b0, 18'h00000, 4'd5, 1'b0, 4'd3, 18'h2ABCD, 1'b1, 1'b1, 1'b1, 3'd1};
    tbl[4]  = '{1'b0, 4'd0, 18'h00000, 1'b0, 4'd0, 1'b0, 18'h00000, 4'd5, 1'b0, 4'd3, 18'h2ABCD, 1'b1, 1'b1, 1'b1, 3'd1};
    tbl[5]  = '{1'b0, 4'd0, 18'h00000, 1'b0, 4'd0, 1'b1, 18'h00123, 4'd5, 1'b0, 4'd3, 18'h2ABCD, 1'b1, 1'b1, 1'b1, 3'd1};
    tbl[6]  = '{1'b0, 4'd0, 18'h00000, 1'b0, 4'd5, 1'b0, 18'h00000, 4'd5, 1'b1, 4'd5, 18'h00123, 1'b1, 1'b1, 1'b0, 3'd0};
    tbl[7]  = '{1'b0, 4'd0, 18'h00000, 1'b0, 4'd5, 1'b0, 18'h00000, 4'd5, 1'b0, 4'd5, 18'h00123, 1'b0, 1'b1, 1'b1, 3'd0};
    tbl[8]  = '{1'b0, 4'd0, 18'h00000, 1'b1, 4'd2, 1'b0, 18'h00000, 4'd0, 1'b0, 4'd5, 18'h00123, 1'b0, 1'b1, 1'b1, 3'd0};
    tbl[9]  = '{1'b1, 4'd7, 18'h22222, 1'b0, 4'd0, 1'b1, 18'h11111, 4'd0, 1'b0, 4'd5, 18'h00123, 1'b0, 1'b1, 1'b1, 3'd1};
    tbl[10] = '{1'b1, 4'd9, 18'h0AAAA, 1'b0, 4'd2, 1'b0, 18'h00000, 4'd0, 1'b1, 4'd2, 18'h11111, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[11] = '{1'b0, 4'd0, 18'h00000, 1'b0, 4'd0, 1'b0, 18'h00000, 4'd0, 1'b1, 4'd7, 18'h22222, 1'b0, 1'b1, 1'b1, 3'd0};
    tbl[12] = '{1'b0, 4'd0, 18'h00000, 1'b0, 4'd0, 1'b0, 18'h00000, 4'd0, 1'b0, 4'd7, 18'h22222, 1'b0, 1'b1, 1'b1, 3'd0};

    rd_vals[0] = 18'h3A001;
    rd_vals[1] = 18'h3B002;
    rd_vals[2] = 18'h3C003;
    rd_vals[3] = 18'h3D004;

    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.RegWrite", 32'(RegWrite), 32'd0);
    chk("reset.ld_count", 32'(ld_count), 32'd0);
    chk("reset.resp_err", 32'(resp_err), 32'd0);
    reset = 1'b1;

    // Directed table: ALU write, load latency/stall, load vs ALU contention.
    for (int i = 0; i < 13; i++) begin
      alu_valid     = tbl[i].av;
      alu_rd        = tbl[i].ard;
      alu_data      = tbl[i].adat;
      ld_req_valid  = tbl[i].lv;
      ld_rd         = tbl[i].lrd;
      ld_resp_valid = tbl[i].rv;
      ld_resp_data  = tbl[i].rdat;
      rs1           = tbl[i].rs;
      #1;
      chk($sformatf("vec%0d.RegWrite", i), 32'(RegWrite), 32'(tbl[i].we));
      chk($sformatf("vec%0d.write_addr", i), 32'(write_addr), 32'(tbl[i].wa));
      chk($sformatf("vec%0d.write_data", i), 32'(write_data), 32'(tbl[i].wd));
      chk($sformatf("vec%0d.stall", i), 32'(stall), 32'(tbl[i].stl));
      chk($sformatf("vec%0d.alu_ready", i), 32'(alu_ready), 32'(tbl[i].ar));
      chk($sformatf("vec%0d.ld_req_ready", i), 32'(ld_req_ready), 32'(tbl[i].lr));
      chk($sformatf("vec%0d.ld_count", i), 32'(ld_count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d.resp_err", i), 32'(resp_err), 32'd0);
      cyc();
    end

    // Fill the tag FIFO, then drain it in order.
    idle();
    for (int i = 1; i <= 4; i++) begin
      ld_req_valid = 1'b1;
      ld_rd        = AW'(i);
      #1;
      chk($sformatf("full.accept%0d", i), 32'(ld_req_ready), 32'd1);
      cyc();
    end
    ld_rd = 4'd6;
    #1;
    chk("full.refuse", 32'(ld_req_ready), 32'd0);
    chk("full.ld_count", 32'(ld_count), 32'd4);
    cyc();
    ld_req_valid = 1'b0;
    ld_rd        = 4'd2;
    for (int j = 0; j <= 4; j++) begin
      ld_resp_valid = (j < 4);
      ld_resp_data  = (j < 4) ? rd_vals[j % 4] : '0;
      #1;
      if (j == 1) chk("full.pending_refuse", 32'(ld_req_ready), 32'd0);
      if (j > 0) begin
        chk($sformatf("drain%0d.RegWrite", j), 32'(RegWrite), 32'd1);
        chk($sformatf("drain%0d.write_addr", j), 32'(write_addr), 32'(j));
        chk($sformatf("drain%0d.write_data", j), 32'(write_data), 32'(rd_vals[j-1]));
      end
      cyc();
    end
    idle();
    #1;
    chk("drain.idle_RegWrite", 32'(RegWrite), 32'd0);
    chk("drain.ld_count", 32'(ld_count), 32'd0);
    cyc();

    // Orphan response: no write, sticky error, cleared only by reset.
    ld_resp_valid = 1'b1;
    ld_resp_data  = 18'h15A5A;
    #1;
    cyc();
    ld_resp_valid = 1'b0;
    #1;
    chk("orphan.RegWrite", 32'(RegWrite), 32'd0);
    chk("orphan.resp_err", 32'(resp_err), 32'd1);
    repeat (3) cyc();
    chk("orphan.resp_err_held", 32'(resp_err), 32'd1);
    reset = 1'b0;
    #1;
    chk("orphan.reset_clears", 32'(resp_err), 32'd0);
    cyc();
    reset = 1'b1;

    // Asynchronous reset with two loads in flight.
    ld_req_valid = 1'b1;
    ld_rd        = 4'd8;
    alu_valid    = 1'b1;
    alu_rd       = 4'd12;
    alu_data     = 18'h15555;
    #1;
    cyc();
    alu_valid = 1'b0;
    ld_rd     = 4'd9;
    #1;
    chk("midrst.pre_RegWrite", 32'(RegWrite), 32'd1);
    chk("midrst.pre_write_addr", 32'(write_addr), 32'd12);
    cyc();
    ld_req_valid = 1'b0;
    rs1          = 4'd8;
    #1;
    chk("midrst.pre_ld_count", 32'(ld_count), 32'd2);
    chk("midrst.pre_stall", 32'(stall), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst.write_addr", 32'(write_addr), 32'd0);
    chk("midrst.write_data", 32'(write_data), 32'd0);
    chk("midrst.ld_count", 32'(ld_count), 32'd0);
    chk("midrst.stall", 32'(stall), 32'd0);
    cyc();
    reset         = 1'b1;
    rs1           = '0;
    ld_resp_valid = 1'b1;
    ld_resp_data  = 18'h00777;
    #1;
    cyc();
    ld_resp_valid = 1'b0;
    #1;
    chk("midrst.late_RegWrite", 32'(RegWrite), 32'd0);
    chk("midrst.late_resp_err", 32'(resp_err), 32'd1);

    // Randomized traffic against the reference model.
    idle();
    reset = 1'b0;
    #1;
    cyc();
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      alu_valid     = 1'($urandom_range(0, 1));
      alu_rd        = AW'($urandom_range(0, 15));
      alu_data      = DW'($urandom);
      ld_req_valid  = ($urandom_range(0, 2) != 0);
      ld_rd         = AW'($urandom_range(1, 6));
      ld_resp_valid = (m_tq.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
      ld_resp_data  = DW'($urandom);
      rs1           = AW'($urandom_range(0, 15));
      rs2           = AW'($urandom_range(0, 15));
      rd_chk        = AW'($urandom_range(0, 15));
      #1;
      model_step(c);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Sole driver of the register file write port (RegWrite, write_addr, write_data); the register file is the consumer of this block.
- Merges single-cycle ALU results with in-order, multi-cycle load responses.
- Keeps a scoreboard of destination registers with a load in flight, so decode can stall on RAW/WAW hazards.
- Sits between the execute/memory stages and the 16 x 18-bit register file.

Parameters:
- DEPTH, 4, max outstanding loads (load tag FIFO depth, power of 2, >=2)
- DW, 18, datapath width
- AW, 4, register address width (16 registers)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous reset, active-low (0 = reset asserted)
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle when alu_valid=1
- alu_rd  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- ld_req_valid  in  1  load issued by memory stage
- ld_req_ready  out  1  load issue accepted (rd reserved)
- ld_rd  in  AW  load destination register
- ld_resp_valid  in  1  load data returning; in order, cannot be back-pressured
- ld_resp_data  in  DW  load data
- rs1, rs2, rd_chk  in  AW each  decode-stage operands to hazard-check
- stall  out  1  decode must hold
- RegWrite  out  1  register file write enable (registered)
- write_addr  out  AW  register file write address (registered)
- write_data  out  DW  register file write data (registered)
- ld_count  out  clog2(DEPTH)+1  outstanding loads
- resp_err  out  1  sticky: response received with no outstanding load

Behaviour:
- Reset (reset=0, async): RegWrite=0, write_addr=0, write_data=0, FIFO empty, ld_count=0, pending mask=0, skid empty, resp_err=0, internal wb_is_load=0.
- Load tag FIFO:
  - Holds ld_rd of each accepted load, in issue order.
  - ld_req_ready = !full && !pending[ld_rd] (combinational). A second load to an already-pending register is refused.
  - Accepted load: push ld_rd and set pending[ld_rd] at that edge.
- Load response with FIFO non-empty: pop head rd; write = {head rd, ld_resp_data}.
- Load response with FIFO empty: ignored, no write; resp_err set until reset.
- Push and pop in the same cycle are both honoured; ld_count is unchanged. Pointers wrap modulo DEPTH.
- Write-port arbitration (one write per cycle), in priority order:
  1. Load response
  2. Skid register (1 entry)
  3. New ALU result
- alu_ready = skid empty (combinational).
- Accepted ALU result that loses to a load response goes into the skid. A skid entry that loses to a load response stays in the skid.
- Pipeline outputs: the selected write is registered. RegWrite/write_addr/write_data appear the cycle after selection; RegWrite=0 in cycles with no selection, and write_addr/write_data hold their last values.
- Latency:
  - ALU result, uncontended: 1 cycle to RegWrite.
  - Load response: 1 cycle to RegWrite.
  - Each competing load response adds 1 cycle to an ALU or skid write.
- Pending clear: pending[write_addr] clears at the edge where RegWrite=1 && wb_is_load, which is the same edge the register file samples the data.
- stall (combinational) = pending[rs1] | pending[rs2] | pending[rd_chk] | (skid full && alu_valid).
- ALU to a pending register: never issued by design (covered by stall on rd_chk). If it does occur, the write still goes through and pending is unaffected.
- Reset mid-operation: all in-flight loads are discarded. Responses arriving after reset release set resp_err.

Test Plan:
- Reset, then alu_valid=1, alu_rd=3, alu_data=0x2ABCD for 1 cycle -> next cycle RegWrite=1, write_addr=3, write_data=0x2ABCD; following cycle RegWrite=0.
- Load to rd=5 accepted; rs1=5 -> stall=1, ld_count=1. ld_resp_valid=1, data=0x00123 three cycles later -> next cycle write 5/0x00123. stall=0 the cycle after that, ld_count=0.
- Same cycle: ld_resp_valid (head rd=2, 0x11111) and ALU rd=7, 0x22222 -> write 2/0x11111 at cycle t+1 and 7/0x22222 at t+2. alu_ready=0 during t+1 only.
- Issue 4 loads to rd 1,2,3,4 -> ld_req_ready=0 on the 5th. Load to a pending rd=2 is also refused. Responses A,B,C,D -> writes to 1,2,3,4 in order.
- ld_resp_valid with no outstanding loads -> no RegWrite, resp_err=1 and held. Assert reset=0 -> resp_err=0.
- Two loads outstanding, assert reset=0 mid-stream -> all outputs and ld_count return to 0 immediately (async). A subsequent response sets resp_err.
